// File: rtl/model_host_bridge.sv
// Host-side bridge: packs a serial sample stream into one model input vector,
// launches the model, then serializes the model's result onto a valid/ready stream.
module model_host_bridge #(
    parameter int InLen         = 10,
    parameter int OutLen        = 3,
    parameter int NBits         = 12,
    parameter int TimeoutCycles = 4096
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          s_valid,
    input  logic [NBits-1:0]              s_data,
    output logic                          s_ready,
    input  logic                          mdl_ready,
    output logic                          mdl_in_strobe,
    output logic [InLen-1:0][NBits-1:0]   mdl_in_vec,
    input  logic                          mdl_out_valid,
    output logic                          mdl_out_rd,
    input  logic [OutLen-1:0][NBits-1:0]  mdl_out_vec,
    output logic                          m_valid,
    output logic [NBits-1:0]              m_data,
    input  logic                          m_ready,
    output logic                          busy,
    output logic                          err_timeout,
    output logic [15:0]                   frame_count,
    output logic [1:0]                    dbg_state
);

    localparam int FW = (InLen > 1) ? $clog2(InLen) : 1;
    localparam int DW = (OutLen > 1) ? $clog2(OutLen) : 1;
    localparam int TW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

    localparam logic [FW-1:0] FILL_LAST  = FW'(InLen - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(OutLen - 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TimeoutCycles - 1);

    // Encoding is visible on dbg_state: FILL=0, LAUNCH_WAIT=1, RUN=2, DRAIN=3.
    typedef enum logic [1:0] {
        FILL        = 2'd0,
        LAUNCH_WAIT = 2'd1,
        RUN         = 2'd2,
        DRAIN       = 2'd3
    } state_t;

    state_t                       state;
    logic [FW-1:0]                fill_cnt;
    logic [DW-1:0]                drain_cnt;
    logic [TW-1:0]                tmo_cnt;
    logic [OutLen-1:0][NBits-1:0] result;

    assign dbg_state = state;

    // Handshakes: a transfer happens on a rising clk_in edge where valid and ready
    // are both high; valid and data hold steady until that edge.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state         <= FILL;
            fill_cnt      <= '0;
            drain_cnt     <= '0;
            tmo_cnt       <= '0;
            result        <= '0;
            s_ready       <= 1'b1;
            mdl_in_strobe <= 1'b0;
            mdl_in_vec    <= '0;
            mdl_out_rd    <= 1'b0;
            m_valid       <= 1'b0;
            m_data        <= '0;
            busy          <= 1'b0;
            err_timeout   <= 1'b0;
            frame_count   <= '0;
        end else begin
            mdl_in_strobe <= 1'b0;
            mdl_out_rd    <= 1'b0;
            case (state)
                FILL: begin
                    if (s_valid && s_ready) begin
                        mdl_in_vec[fill_cnt] <= s_data;
                        busy                 <= 1'b1;
                        if (fill_cnt == FILL_LAST) begin
                            fill_cnt <= '0;
                            s_ready  <= 1'b0;
                            // An idle model is launched straight away, so LAUNCH_WAIT
                            // only lasts while the model is still busy.
                            if (mdl_ready) begin
                                mdl_in_strobe <= 1'b1;
                                tmo_cnt       <= '0;
                                state         <= RUN;
                            end else begin
                                state <= LAUNCH_WAIT;
                            end
                        end else begin
                            fill_cnt <= fill_cnt + 1'b1;
                        end
                    end
                end
                LAUNCH_WAIT: begin
                    if (mdl_ready) begin
                        mdl_in_strobe <= 1'b1;
                        tmo_cnt       <= '0;
                        state         <= RUN;
                    end
                end
                RUN: begin
                    if (mdl_out_valid) begin
                        result     <= mdl_out_vec;
                        mdl_out_rd <= 1'b1;
                        m_valid    <= 1'b1;
                        m_data     <= mdl_out_vec[0];
                        drain_cnt  <= '0;
                        state      <= DRAIN;
                    end else if (tmo_cnt == TMO_LAST) begin
                        err_timeout <= 1'b1;
                        s_ready     <= 1'b1;
                        busy        <= 1'b0;
                        state       <= FILL;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (m_ready) begin
                        if (drain_cnt == DRAIN_LAST) begin
                            m_valid     <= 1'b0;
                            frame_count <= frame_count + 16'd1;
                            drain_cnt   <= '0;
                            s_ready     <= 1'b1;
                            busy        <= 1'b0;
                            state       <= FILL;
                        end else begin
                            drain_cnt <= drain_cnt + 1'b1;
                            m_data    <= result[drain_cnt + 1'b1];
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_model_host_bridge.sv
// Directed + randomized bench for model_host_bridge with a latency-programmable model stub.
module tb_model_host_bridge;

    localparam int IN_LEN  = 10;
    localparam int OUT_LEN = 3;
    localparam int NB      = 12;
    localparam int TMO     = 16;

    logic                          clk_in;
    logic                          rst_in;
    logic                          s_valid;
    logic [NB-1:0]                 s_data;
    logic                          s_ready;
    logic                          mdl_ready;
    logic                          mdl_in_strobe;
    logic [IN_LEN-1:0][NB-1:0]     mdl_in_vec;
    logic                          mdl_out_valid;
    logic                          mdl_out_rd;
    logic [OUT_LEN-1:0][NB-1:0]    mdl_out_vec = '0;
    logic                          m_valid;
    logic [NB-1:0]                 m_data;
    logic                          m_ready;
    logic                          busy;
    logic                          err_timeout;
    logic [15:0]                   frame_count;
    logic [1:0]                    dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    int n_strobe = 0;
    int n_rd     = 0;
    int base_strobe;
    int base_rd;

    logic [NB-1:0] exp_q[$];
    logic [15:0]   model_frames = 16'd0;

    logic stub_valid = 1'b0;
    bit   stub_pend  = 1'b0;
    bit   stub_dead  = 1'b0;
    bit   spur       = 1'b0;
    int   stub_cnt   = 0;
    int   stub_lat   = 5;

    model_host_bridge #(
        .InLen(IN_LEN), .OutLen(OUT_LEN), .NBits(NB), .TimeoutCycles(TMO)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .mdl_ready(mdl_ready), .mdl_in_strobe(mdl_in_strobe), .mdl_in_vec(mdl_in_vec),
        .mdl_out_valid(mdl_out_valid), .mdl_out_rd(mdl_out_rd), .mdl_out_vec(mdl_out_vec),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .busy(busy), .err_timeout(err_timeout), .frame_count(frame_count),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // pulse counters for strobe and pop
    always @(posedge clk_in) begin
        if (mdl_in_strobe === 1'b1) n_strobe <= n_strobe + 1;
        if (mdl_out_rd === 1'b1)    n_rd     <= n_rd + 1;
    end

    // model stub: echoes elements 0..OUT_LEN-1 plus one after stub_lat cycles
    assign mdl_out_valid = stub_valid | spur;
    always @(negedge clk_in) begin
        if (!rst_in) begin
            stub_valid = 1'b0;
            stub_pend  = 1'b0;
            stub_cnt   = 0;
        end else begin
            if (mdl_out_rd) stub_valid = 1'b0;
            if (mdl_in_strobe) begin
                if (!stub_dead) begin
                    stub_pend = 1'b1;
                    stub_cnt  = stub_lat;
                    for (int j = 0; j < OUT_LEN; j++) mdl_out_vec[j] = mdl_in_vec[j] + 12'd1;
                end
            end else if (stub_pend) begin
                stub_cnt--;
                if (stub_cnt == 0) begin
                    stub_pend  = 1'b0;
                    stub_valid = 1'b1;
                end
            end
        end
    end

    // scoreboard compare
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // drivers
    task automatic push_sample(input logic [NB-1:0] d);
        int w = 0;
        s_valid = 1'b1;
        s_data  = d;
        while (s_ready !== 1'b1 && w < 50) begin
            @(negedge clk_in);
            w++;
        end
        check("push_ready_wait", 128'(w < 50), 128'd1);
        @(negedge clk_in);
        s_valid = 1'b0;
    endtask

    task automatic launch_frame(input logic [IN_LEN-1:0][NB-1:0] samples,
                                input int gap_max, input int busy_cycles);
        base_strobe = n_strobe;
        base_rd     = n_rd;
        for (int i = 0; i < IN_LEN; i++) begin
            repeat ($urandom_range(0, gap_max)) @(negedge clk_in);
            if (i == IN_LEN - 1 && busy_cycles > 0) mdl_ready = 1'b0;
            push_sample(samples[i]);
            if (i == 0) check("busy_after_first", busy, 1);
        end
        for (int j = 0; j < OUT_LEN; j++) exp_q.push_back(samples[j] + 12'd1);
        if (busy_cycles > 0) begin
            for (int c = 0; c < busy_cycles; c++) begin
                check("wait_no_strobe", mdl_in_strobe, 0);
                check("wait_s_ready", s_ready, 0);
                @(negedge clk_in);
            end
            mdl_ready = 1'b1;
            @(negedge clk_in);
        end
        check("strobe_high", mdl_in_strobe, 1);
        check("in_vec", mdl_in_vec, samples);
        check("launch_s_ready", s_ready, 0);
        @(negedge clk_in);
        check("strobe_one_cycle", mdl_in_strobe, 0);
        check("in_vec_held", mdl_in_vec, samples);
    endtask

    task automatic drain_frame(input int mr_mode);
        int  w = 0;
        int  k = 0;
        int  guard = 0;
        bit  mr;
        while (m_valid !== 1'b1 && w < 200) begin
            @(negedge clk_in);
            w++;
        end
        check("result_latency", w, stub_lat);
        check("rd_pulse", mdl_out_rd, 1);
        while (k < OUT_LEN && guard < 100) begin
            case (mr_mode)
                0:       mr = 1'b1;
                1:       mr = (guard % 2 == 1);
                default: mr = 1'($urandom_range(0, 1));
            endcase
            m_ready = mr;
            check("drain_valid", m_valid, 1);
            check("drain_data", m_data, exp_q[0]);
            check("drain_s_ready", s_ready, 0);
            @(negedge clk_in);
            if (mr) begin
                void'(exp_q.pop_front());
                k++;
            end
            guard++;
        end
        m_ready = 1'b0;
        model_frames = model_frames + 16'd1;
        check("drain_done", k, OUT_LEN);
        check("m_valid_drop", m_valid, 0);
        check("frame_count", frame_count, model_frames);
        check("one_rd", n_rd - base_rd, 1);
        check("one_strobe", n_strobe - base_strobe, 1);
        check("s_ready_back", s_ready, 1);
        check("busy_idle", busy, 0);
        check("state_fill", dbg_state, 0);
    endtask

    initial begin
        logic [IN_LEN-1:0][NB-1:0] smp;

        rst_in    = 1'b0;
        s_valid   = 1'b0;
        s_data    = '0;
        mdl_ready = 1'b1;
        m_ready   = 1'b0;
        repeat (3) @(negedge clk_in);

        // reset values
        check("rst_s_ready", s_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_vec", mdl_in_vec, 0);
        check("rst_strobe", mdl_in_strobe, 0);
        check("rst_err", err_timeout, 0);
        check("rst_frames", frame_count, 0);
        rst_in = 1'b1;
        @(negedge clk_in);

        // single frame 1..10, latency 5, echo +1
        for (int i = 0; i < IN_LEN; i++) smp[i] = NB'(i + 1);
        stub_lat = 5;
        launch_frame(smp, 0, 0);
        drain_frame(0);

        // downstream backpressure
        for (int i = 0; i < IN_LEN; i++) smp[i] = NB'($urandom_range(0, 4095));
        launch_frame(smp, 1, 0);
        drain_frame(1);

        // model busy for 20 cycles
        for (int i = 0; i < IN_LEN; i++) smp[i] = NB'($urandom_range(0, 4095));
        launch_frame(smp, 0, 20);
        drain_frame(0);

        // result valid outside RUN is ignored
        base_rd = n_rd;
        spur = 1'b1;
        repeat (3) @(negedge clk_in);
        spur = 1'b0;
        @(negedge clk_in);
        check("spur_no_rd", n_rd - base_rd, 0);
        check("spur_state", dbg_state, 0);
        check("spur_m_valid", m_valid, 0);

        // timeout abort, then a normal frame
        stub_dead = 1'b1;
        for (int i = 0; i < IN_LEN; i++) smp[i] = NB'($urandom_range(0, 4095));
        launch_frame(smp, 0, 0);
        exp_q.delete();
        repeat (14) @(negedge clk_in);
        check("tmo_not_early", err_timeout, 0);
        check("tmo_in_run", dbg_state, 2);
        @(negedge clk_in);
        check("tmo_err", err_timeout, 1);
        check("tmo_state", dbg_state, 0);
        check("tmo_s_ready", s_ready, 1);
        check("tmo_frames", frame_count, model_frames);
        check("tmo_no_rd", n_rd - base_rd, 0);
        stub_dead = 1'b0;
        for (int i = 0; i < IN_LEN; i++) smp[i] = NB'($urandom_range(0, 4095));
        launch_frame(smp, 0, 0);
        drain_frame(0);
        check("tmo_sticky", err_timeout, 1);

        // reset mid-frame drops partial input
        for (int i = 0; i < 6; i++) push_sample(NB'($urandom_range(1, 4095)));
        rst_in = 1'b0;
        #1;
        check("mid_rst_vec", mdl_in_vec, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_s_ready", s_ready, 1);
        check("mid_rst_err", err_timeout, 0);
        check("mid_rst_frames", frame_count, 0);
        model_frames = 16'd0;
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        check("post_rst_no_strobe", mdl_in_strobe, 0);
        for (int i = 0; i < IN_LEN; i++) smp[i] = NB'($urandom_range(0, 4095));
        launch_frame(smp, 0, 0);
        drain_frame(0);

        // randomized frames
        for (int f = 0; f < 4; f++) begin
            stub_lat = $urandom_range(1, 8);
            for (int i = 0; i < IN_LEN; i++) smp[i] = NB'($urandom_range(0, 4095));
            launch_frame(smp, 2, $urandom_range(0, 3));
            drain_frame(2);
        end

        // frame counter wrap
        force dut.frame_count = 16'hFFFF;
        @(negedge clk_in);
        release dut.frame_count;
        @(negedge clk_in);
        check("wrap_preload", frame_count, 16'hFFFF);
        model_frames = 16'hFFFF;
        stub_lat = 5;
        for (int i = 0; i < IN_LEN; i++) smp[i] = NB'($urandom_range(0, 4095));
        launch_frame(smp, 0, 0);
        drain_frame(0);
        check("wrap_zero", frame_count, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/model_host_bridge.md
Name: model_host_bridge

Overview:
- Host-side counterpart to the generated network top levels.
- Packs a serial 12-bit sample stream into one InLen-element input vector and launches it into the model with a single-cycle write strobe.
- Waits for the model's result, pops the OutLen-element output vector and serializes it onto a valid/ready output stream.
- Sits between the audio-feature front end and any model top level that exposes module_ready, in_data_ready, out_data_valid and rd_out_top.

Parameters:
- InLen, 10, elements per model input vector
- OutLen, 3, elements per model output vector
- NBits, 12, bits per element (two's complement)
- TimeoutCycles, 4096, max cycles from launch to result before abort

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  asynchronous, active-low reset
- s_valid  in  1  input sample valid
- s_data  in  NBits  input sample
- s_ready  out  1  bridge accepts sample
- mdl_ready  in  1  model idle (model's module_ready)
- mdl_in_strobe  out  1  one-cycle launch (drives model in_data_ready)
- mdl_in_vec  out  [InLen][NBits]  packed input vector, element 0 = first sample
- mdl_out_valid  in  1  model result available (model out_data_valid)
- mdl_out_rd  out  1  one-cycle pop of model output FIFO (model rd_out_top)
- mdl_out_vec  in  [OutLen][NBits]  model result vector
- m_valid  out  1  output element valid
- m_data  out  NBits  output element, element 0 first
- m_ready  in  1  downstream accepts element
- busy  out  1  state != FILL or fill count != 0
- err_timeout  out  1  sticky; set on timeout abort
- frame_count  out  16  completed frames, wraps at 16'hFFFF -> 0

Behaviour:
- Reset (async assert, sync release). State FILL; fill/drain counters 0; s_ready=1; mdl_in_strobe=0; mdl_out_rd=0; m_valid=0; m_data=0; mdl_in_vec=0; err_timeout=0; frame_count=0; busy=0.
- FSM states: FILL, LAUNCH_WAIT, RUN, DRAIN.
- FILL:
  - s_ready=1.
  - Each s_valid&&s_ready cycle writes s_data into mdl_in_vec[fill_cnt] and increments fill_cnt.
  - On the InLen-th accept: fill_cnt->0, go to LAUNCH_WAIT.
- LAUNCH_WAIT:
  - s_ready=0.
  - When mdl_ready=1: assert mdl_in_strobe for exactly one cycle, clear the timeout counter, go to RUN.
  - mdl_in_vec is held stable from the last FILL write until the cycle after the strobe.
- RUN:
  - s_ready=0; the timeout counter increments each cycle.
  - First cycle with mdl_out_valid=1: register mdl_out_vec into an internal result buffer, pulse mdl_out_rd for one cycle, go to DRAIN. mdl_out_vec is stable in the cycle mdl_out_valid is high.
  - If the counter reaches TimeoutCycles-1 with no mdl_out_valid: set err_timeout, no mdl_out_rd, return to FILL.
  - If mdl_out_valid and timeout occur in the same cycle, the result wins.
- DRAIN:
  - m_valid=1; m_data=result[drain_cnt].
  - drain_cnt advances on m_valid&&m_ready; m_data stays stable while m_ready=0.
  - After OutLen handshakes: m_valid=0 the next cycle, frame_count+1, return to FILL.
  - s_ready=0 during DRAIN (no overlap; one frame in flight).
- Latency:
  - Last input accept -> mdl_in_strobe: ≥1 cycle (exactly 1 if mdl_ready is already high).
  - mdl_out_valid -> first m_valid: 1 cycle.
- mdl_out_valid seen outside RUN is ignored (no pop).
- err_timeout clears only on reset.
- Asserting rst_in mid-frame drops all partial input/output data immediately; outputs take reset values asynchronously.
- All outputs are registered. No arithmetic on element data; pure transport.

Test Plan:
- Single frame, InLen=10/OutLen=3, model stub echoes elements 0..2 plus 1 with 5-cycle latency: feed 1..10 → one mdl_in_strobe with mdl_in_vec=[1..10]; m_data sequence 2,3,4; frame_count=1; one mdl_out_rd pulse.
- Backpressure: m_ready toggles 0/1 each cycle during DRAIN → each element is held until accepted; no duplicates or drops; s_ready stays 0 until the third handshake completes.
- Model busy: mdl_ready=0 for 20 cycles after the 10th sample → no strobe until mdl_ready rises; strobe then 1 cycle; s_ready=0 throughout.
- Timeout, TimeoutCycles=16, stub never asserts mdl_out_valid → err_timeout=1 exactly 16 cycles after the strobe; state back to FILL; frame_count unchanged; the next frame completes normally and err_timeout stays 1.
- Reset mid-frame: drop rst_in after 6 samples, release, feed 10 fresh samples → mdl_in_vec holds only the fresh samples; no stray strobe.
- Wrap: preload/force frame_count=16'hFFFF, complete one frame → frame_count=0.
